multi_slot_keeper: RTL and testbench
====================================

MULTI_SLOT_KEEPER -- requirements
Module: multi_slot_keeper

Interface
REQ-001 SHALL have parameter PORT_COUNT, default 4: number of independent slot pools (ports).
REQ-002 SHALL have parameter SLOT_COUNT, default 8: maximum slots per port, numbered 1..SLOT_COUNT; slot 0 means "no slot".
REQ-003 SHALL have parameter SLOT_WIDTH, default $clog2(SLOT_COUNT+1): width of one slot number.
REQ-004 SHALL have parameter PORT_WIDTH, default max(1,$clog2(PORT_COUNT)): width of a port index.
REQ-005 clk  in  1  clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 init_port  in  PORT_WIDTH  port to initialise.
REQ-008 init_slots  in  SLOT_WIDTH  slots 1..init_slots become free; values above SLOT_COUNT saturate to SLOT_COUNT.
REQ-009 init_valid  in  1  init strobe.
REQ-010 slot_in_port  in  PORT_WIDTH  port owning the returned slot.
REQ-011 slot_in  in  SLOT_WIDTH  returned (freed) slot number.
REQ-012 slot_in_valid  in  1  return strobe; no backpressure.
REQ-013 slot_out  out  PORT_COUNT*SLOT_WIDTH  per-port offered slot, port p at bits [p*SLOT_WIDTH +: SLOT_WIDTH].
REQ-014 slot_out_valid  out  PORT_COUNT  per-port offer valid.
REQ-015 slot_out_pop  in  PORT_COUNT  per-port consume of offered slot.
REQ-016 slot_count  out  PORT_COUNT*(SLOT_WIDTH)  per-port free-slot count.
REQ-017 enq_err  out  PORT_COUNT  per-port sticky error flag.
REQ-018 err_slot  out  PORT_COUNT*SLOT_WIDTH  per-port first offending slot number.

Function
REQ-019 Each port SHALL keep a SLOT_COUNT-bit free bitmap; bit s set = slot s free.
REQ-020 slot_out[p] SHALL be the lowest-numbered free slot of port p, combinational from the bitmap; 0 when bitmap empty.
REQ-021 slot_out_valid[p] SHALL equal (bitmap[p] != 0), combinational from the registered bitmap; an enqueue is visible one cycle after its strobe.
REQ-022 Pop on port p with slot_out_valid[p]=1 SHALL clear the offered bit next cycle; pop with valid=0 SHALL be ignored, no error.
REQ-023 Valid return (slot_in in 1..SLOT_COUNT, bit clear) SHALL set the bit next cycle.
REQ-024 slot_in=0 SHALL be ignored silently.
REQ-025 Return of an already-free slot or slot_in > SLOT_COUNT SHALL leave the bitmap unchanged, set enq_err[p] next cycle, and latch err_slot[p] only if enq_err[p] was 0.
REQ-026 slot_in_port >= PORT_COUNT SHALL be ignored with no error.
REQ-027 Return and pop on the same port same cycle SHALL both apply; a return of the slot being popped is an error per REQ-025, and the pop still clears it.
REQ-028 init_valid on port p SHALL load bitmap bits 1..init_slots set, others clear, clear enq_err[p] and err_slot[p], and override any same-cycle return or pop on that port; other ports unaffected.
REQ-029 slot_count[p] SHALL be a registered popcount kept incrementally: +1 on effective return, -1 on effective pop, unchanged when both, loaded with saturated init_slots on init; it SHALL always equal the bitmap popcount.
REQ-030 Counters SHALL never wrap: count stays within 0..SLOT_COUNT by construction of REQ-022/025.

Reset
REQ-031 On rst all bitmaps SHALL clear, slot_count=0, slot_out_valid=0, slot_out=0, enq_err=0, err_slot=0, taking effect the next edge.
REQ-032 rst SHALL override init, return and pop in the same cycle; mid-operation reset SHALL discard all pool state.

Structure
REQ-033 No shared package; SLOT_WIDTH/PORT_WIDTH are derived parameters overridable by parent.
REQ-034 One sub-module slot_pool (single-port bitmap, priority encoder, count, error capture) SHALL be instantiated PORT_COUNT times via generate; top decodes init_port/slot_in_port to per-port strobes.

Verification
REQ-035 Reset, init port 2 with 3 -> next cycle slot_out[2]=1, valid[2]=1, slot_count[2]=3, other ports valid=0.
REQ-036 Pop port 2 three cycles -> offers 1,2,3 then valid[2]=0, slot_count[2]=0; fourth pop ignored, no error.
REQ-037 Return slot 2 to port 2 while popping slot 1 -> next cycle count unchanged, slot_out[2]=2.
REQ-038 Return slot 3 twice to port 1 (init 3) -> enq_err[1]=1, err_slot[1]=3, count[1]=3; later return slot 9 keeps err_slot[1]=3.
REQ-039 Init port 0 with 15 (SLOT_COUNT=8) concurrent with return to port 0 -> count[0]=8, enq_err[0]=0.
REQ-040 Assert rst during traffic on all ports -> all outputs 0 next cycle; returns that cycle ignored.

Source files
------------

// File: rtl/multi_slot_keeper_slot_pool.sv
// Single-port slot pool: free bitmap, lowest-free priority encoder,
// incremental free count and sticky first-error capture.
module slot_pool #(
  parameter int SLOT_COUNT = 8,
  parameter int SLOT_WIDTH = $clog2(SLOT_COUNT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_valid,
  input  logic [SLOT_WIDTH-1:0] init_slots,
  input  logic                  ret_valid,
  input  logic [SLOT_WIDTH-1:0] ret_slot,
  input  logic                  pop,
  output logic [SLOT_WIDTH-1:0] slot_out,
  output logic                  slot_out_valid,
  output logic [SLOT_WIDTH-1:0] slot_count,
  output logic                  enq_err,
  output logic [SLOT_WIDTH-1:0] err_slot
);

  localparam logic [SLOT_WIDTH-1:0] MAX_SLOT = SLOT_WIDTH'(SLOT_COUNT);

  // Bit i of the bitmap represents slot i+1 (slot 0 is "no slot").
  logic [SLOT_COUNT-1:0] bitmap_r;
  logic [SLOT_WIDTH-1:0] count_r;
  logic                  enq_err_r;
  logic [SLOT_WIDTH-1:0] err_slot_r;

  logic [SLOT_WIDTH-1:0] offer_slot_s;
  logic [SLOT_COUNT-1:0] offer_mask_s;
  logic [SLOT_COUNT-1:0] ret_mask_s;
  logic [SLOT_COUNT-1:0] init_mask_s;
  logic [SLOT_COUNT-1:0] next_bitmap_s;
  logic [SLOT_WIDTH-1:0] next_count_s;
  logic [SLOT_WIDTH-1:0] sat_init_s;
  logic                  pop_ok_s;
  logic                  ret_in_range_s;
  logic                  ret_dup_s;
  logic                  ret_ok_s;
  logic                  ret_err_s;

  // Lowest free slot: scan high to low so the lowest set bit wins.
  always_comb begin
    offer_slot_s = {SLOT_WIDTH{1'b0}};
    offer_mask_s = {SLOT_COUNT{1'b0}};
    for (int i = SLOT_COUNT - 1; i >= 0; i--) begin
      if (bitmap_r[i]) begin
        offer_slot_s    = SLOT_WIDTH'(i + 1);
        offer_mask_s    = {SLOT_COUNT{1'b0}};
        offer_mask_s[i] = 1'b1;
      end else begin
        offer_slot_s = offer_slot_s;
      end
    end
  end

  // Classify the return, saturate init, and form the next bitmap and count.
  always_comb begin
    for (int i = 0; i < SLOT_COUNT; i++) begin
      ret_mask_s[i] = (ret_slot == SLOT_WIDTH'(i + 1));
    end
    if (init_slots > MAX_SLOT) begin
      sat_init_s = MAX_SLOT;
    end else begin
      sat_init_s = init_slots;
    end
    for (int i = 0; i < SLOT_COUNT; i++) begin
      init_mask_s[i] = (SLOT_WIDTH'(i + 1) <= sat_init_s);
    end
    pop_ok_s       = pop & (|bitmap_r);
    ret_in_range_s = (ret_slot != {SLOT_WIDTH{1'b0}}) && (ret_slot <= MAX_SLOT);
    // Duplicate check uses the registered bitmap, so returning the slot
    // being popped this cycle still counts as an error.
    ret_dup_s      = |(ret_mask_s & bitmap_r);
    ret_ok_s       = ret_valid & ret_in_range_s & ~ret_dup_s;
    ret_err_s      = ret_valid & (ret_slot != {SLOT_WIDTH{1'b0}}) & (~ret_in_range_s | ret_dup_s);
    next_bitmap_s  = (bitmap_r & ~(offer_mask_s & {SLOT_COUNT{pop_ok_s}}))
                   | (ret_mask_s & {SLOT_COUNT{ret_ok_s}});
    case ({ret_ok_s, pop_ok_s})
      2'b10:   next_count_s = count_r + SLOT_WIDTH'(1);
      2'b01:   next_count_s = count_r - SLOT_WIDTH'(1);
      default: next_count_s = count_r;
    endcase
  end

  // Pool state: reset beats init, init beats same-cycle return/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      bitmap_r   <= {SLOT_COUNT{1'b0}};
      count_r    <= {SLOT_WIDTH{1'b0}};
      enq_err_r  <= 1'b0;
      err_slot_r <= {SLOT_WIDTH{1'b0}};
    end else if (init_valid) begin
      bitmap_r   <= init_mask_s;
      count_r    <= sat_init_s;
      enq_err_r  <= 1'b0;
      err_slot_r <= {SLOT_WIDTH{1'b0}};
    end else begin
      bitmap_r <= next_bitmap_s;
      count_r  <= next_count_s;
      if (ret_err_s && !enq_err_r) begin
        enq_err_r  <= 1'b1;
        err_slot_r <= ret_slot;
      end else begin
        enq_err_r  <= enq_err_r;
        err_slot_r <= err_slot_r;
      end
    end
  end

  assign slot_out       = offer_slot_s;
  assign slot_out_valid = |bitmap_r;
  assign slot_count     = count_r;
  assign enq_err        = enq_err_r;
  assign err_slot       = err_slot_r;

endmodule

// File: rtl/multi_slot_keeper.sv
// Multi-port slot keeper: decodes init/return strobes to per-port pools.
module multi_slot_keeper #(
  parameter int PORT_COUNT = 4,
  parameter int SLOT_COUNT = 8,
  parameter int SLOT_WIDTH = $clog2(SLOT_COUNT + 1),
  parameter int PORT_WIDTH = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PORT_WIDTH-1:0]            init_port,
  input  logic [SLOT_WIDTH-1:0]            init_slots,
  input  logic                             init_valid,
  input  logic [PORT_WIDTH-1:0]            slot_in_port,
  input  logic [SLOT_WIDTH-1:0]            slot_in,
  input  logic                             slot_in_valid,
  output logic [PORT_COUNT*SLOT_WIDTH-1:0] slot_out,
  output logic [PORT_COUNT-1:0]            slot_out_valid,
  input  logic [PORT_COUNT-1:0]            slot_out_pop,
  output logic [PORT_COUNT*SLOT_WIDTH-1:0] slot_count,
  output logic [PORT_COUNT-1:0]            enq_err,
  output logic [PORT_COUNT*SLOT_WIDTH-1:0] err_slot
);

  logic [PORT_COUNT-1:0] init_hit_s;
  logic [PORT_COUNT-1:0] ret_hit_s;

  // Port indices at or above PORT_COUNT match no pool and are dropped.
  for (genvar p = 0; p < PORT_COUNT; p++) begin : g_pool
    assign init_hit_s[p] = init_valid & (init_port == PORT_WIDTH'(p));
    assign ret_hit_s[p]  = slot_in_valid & (slot_in_port == PORT_WIDTH'(p));

    slot_pool #(
      .SLOT_COUNT (SLOT_COUNT),
      .SLOT_WIDTH (SLOT_WIDTH)
    ) u_pool (
      .clk            (clk),
      .rst            (rst),
      .init_valid     (init_hit_s[p]),
      .init_slots     (init_slots),
      .ret_valid      (ret_hit_s[p]),
      .ret_slot       (slot_in),
      .pop            (slot_out_pop[p]),
      .slot_out       (slot_out[p*SLOT_WIDTH +: SLOT_WIDTH]),
      .slot_out_valid (slot_out_valid[p]),
      .slot_count     (slot_count[p*SLOT_WIDTH +: SLOT_WIDTH]),
      .enq_err        (enq_err[p]),
      .err_slot       (err_slot[p*SLOT_WIDTH +: SLOT_WIDTH])
    );
  end

endmodule

// File: tb/tb_multi_slot_keeper.sv
// Self-checking bench for multi_slot_keeper (4 ports, 8 slots).
module tb_multi_slot_keeper;

  localparam int PC = 4;
  localparam int SC = 8;
  localparam int SW = 4;
  localparam int PW = 2;

  logic             clk;
  logic             rst;
  logic [PW-1:0]    init_port;
  logic [SW-1:0]    init_slots;
  logic             init_valid;
  logic [PW-1:0]    slot_in_port;
  logic [SW-1:0]    slot_in;
  logic             slot_in_valid;
  logic [PC*SW-1:0] slot_out;
  logic [PC-1:0]    slot_out_valid;
  logic [PC-1:0]    slot_out_pop;
  logic [PC*SW-1:0] slot_count;
  logic [PC-1:0]    enq_err;
  logic [PC*SW-1:0] err_slot;

  multi_slot_keeper #(.PORT_COUNT(PC), .SLOT_COUNT(SC)) dut (
    .clk            (clk),
    .rst            (rst),
    .init_port      (init_port),
    .init_slots     (init_slots),
    .init_valid     (init_valid),
    .slot_in_port   (slot_in_port),
    .slot_in        (slot_in),
    .slot_in_valid  (slot_in_valid),
    .slot_out       (slot_out),
    .slot_out_valid (slot_out_valid),
    .slot_out_pop   (slot_out_pop),
    .slot_count     (slot_count),
    .enq_err        (enq_err),
    .err_slot       (err_slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          iv;
    logic [PW-1:0] ip;
    logic [SW-1:0] is;
    logic          rv;
    logic [PW-1:0] rp;
    logic [SW-1:0] rs;
    logic [PC-1:0] pop;
    logic [PW-1:0] chk;
    logic [PC-1:0] e_valid;
    logic [SW-1:0] e_slot;
    logic [SW-1:0] e_count;
    logic          e_err;
    logic [SW-1:0] e_err_slot;
  } vec_t;

  typedef struct {
    logic [PW-1:0] chk;
    logic [PC-1:0] e_valid;
    logic [SW-1:0] e_slot;
    logic [SW-1:0] e_count;
    logic          e_err;
    logic [SW-1:0] e_err_slot;
  } exp_t;

  vec_t vecs[20];
  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  // Drive one vector, queue its expectation, then compare after the edge.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    rst           = v.rst;
    init_valid    = v.iv;
    init_port     = v.ip;
    init_slots    = v.is;
    slot_in_valid = v.rv;
    slot_in_port  = v.rp;
    slot_in       = v.rs;
    slot_out_pop  = v.pop;
    e.chk = v.chk; e.e_valid = v.e_valid; e.e_slot = v.e_slot;
    e.e_count = v.e_count; e.e_err = v.e_err; e.e_err_slot = v.e_err_slot;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_miss++;
      $display("FAIL scoreboard_empty vec=%0d actual=0 required=1", idx);
    end else begin
      got = sb_q.pop_front();
      check("valid_all", idx, 32'(slot_out_valid), 32'(got.e_valid));
      check("slot_out",  idx, 32'(slot_out[got.chk*SW +: SW]),   32'(got.e_slot));
      check("count",     idx, 32'(slot_count[got.chk*SW +: SW]), 32'(got.e_count));
      check("enq_err",   idx, 32'(enq_err[got.chk]),             32'(got.e_err));
      check("err_slot",  idx, 32'(err_slot[got.chk*SW +: SW]),   32'(got.e_err_slot));
    end
  endtask

  function automatic vec_t idle(input logic [PW-1:0] chk);
    vec_t v;
    v = '{1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0, 4'b0000, chk, 4'b0000, 4'd0, 4'd0, 1'b0, 4'd0};
    return v;
  endfunction

  initial begin
    vec_t v;
    rst = 1'b1; init_valid = 1'b0; init_port = '0; init_slots = '0;
    slot_in_valid = 1'b0; slot_in_port = '0; slot_in = '0; slot_out_pop = '0;

    //          rst   iv    ip    is     rv    rp    rs     pop      chk   e_valid  slot   cnt    err   eslot
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 4'd0,  1'b0, 2'd0, 4'd0,  4'b0000, 2'd0, 4'b0000, 4'd0, 4'd0, 1'b0, 4'd0};
    vecs[1]  = '{1'b0, 1'b1, 2'd2, 4'd3,  1'b0, 2'd0, 4'd0,  4'b0000, 2'd2, 4'b0100, 4'd1, 4'd3, 1'b0, 4'd0};
    vecs[2]  = '{1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 2'd0, 4'd0,  4'b0100, 2'd2, 4'b0100, 4'd2, 4'd2, 1'b0, 4'd0};
    vecs[3]  = '{1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 2'd0, 4'd0,  4'b0100, 2'd2, 4'b0100, 4'd3, 4'd1, 1'b0, 4'd0};
    vecs[4]  = '{1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 2'd0, 4'd0,  4'b0100, 2'd2, 4'b0000, 4'd0, 4'd0, 1'b0, 4'd0};
    vecs[5]  = '{1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 2'd0, 4'd0,  4'b0100, 2'd2, 4'b0000, 4'd0, 4'd0, 1'b0, 4'd0};
    vecs[6]  = '{1'b0, 1'b0, 2'd0, 4'd0,  1'b1, 2'd2, 4'd1,  4'b0000, 2'd2, 4'b0100, 4'd1, 4'd1, 1'b0, 4'd0};
    vecs[7]  = '{1'b0, 1'b0, 2'd0, 4'd0,  1'b1, 2'd2, 4'd3,  4'b0000, 2'd2, 4'b0100, 4'd1, 4'd2, 1'b0, 4'd0};
    vecs[8]  = '{1'b0, 1'b0, 2'd0, 4'd0,  1'b1, 2'd2, 4'd2,  4'b0100, 2'd2, 4'b0100, 4'd2, 4'd2, 1'b0, 4'd0};
    vecs[9]  = '{1'b0, 1'b1, 2'd1, 4'd3,  1'b0, 2'd0, 4'd0,  4'b0000, 2'd1, 4'b0110, 4'd1, 4'd3, 1'b0, 4'd0};
    vecs[10] = '{1'b0, 1'b0, 2'd0, 4'd0,  1'b1, 2'd1, 4'd3,  4'b0000, 2'd1, 4'b0110, 4'd1, 4'd3, 1'b1, 4'd3};
    vecs[11] = '{1'b0, 1'b0, 2'd0, 4'd0,  1'b1, 2'd1, 4'd3,  4'b0000, 2'd1, 4'b0110, 4'd1, 4'd3, 1'b1, 4'd3};
    vecs[12] = '{1'b0, 1'b0, 2'd0, 4'd0,  1'b1, 2'd1, 4'd9,  4'b0000, 2'd1, 4'b0110, 4'd1, 4'd3, 1'b1, 4'd3};
    vecs[13] = '{1'b0, 1'b0, 2'd0, 4'd0,  1'b1, 2'd1, 4'd0,  4'b0000, 2'd1, 4'b0110, 4'd1, 4'd3, 1'b1, 4'd3};
    vecs[14] = '{1'b0, 1'b1, 2'd0, 4'd15, 1'b1, 2'd0, 4'd2,  4'b0001, 2'd0, 4'b0111, 4'd1, 4'd8, 1'b0, 4'd0};
    vecs[15] = '{1'b0, 1'b0, 2'd0, 4'd0,  1'b1, 2'd0, 4'd1,  4'b0001, 2'd0, 4'b0111, 4'd2, 4'd7, 1'b1, 4'd1};
    vecs[16] = '{1'b0, 1'b1, 2'd1, 4'd3,  1'b0, 2'd0, 4'd0,  4'b0000, 2'd1, 4'b0111, 4'd1, 4'd3, 1'b0, 4'd0};
    vecs[17] = '{1'b0, 1'b1, 2'd3, 4'd0,  1'b0, 2'd0, 4'd0,  4'b0000, 2'd3, 4'b0111, 4'd0, 4'd0, 1'b0, 4'd0};
    vecs[18] = '{1'b1, 1'b1, 2'd3, 4'd5,  1'b1, 2'd2, 4'd1,  4'b1111, 2'd2, 4'b0000, 4'd0, 4'd0, 1'b0, 4'd0};
    vecs[19] = '{1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 2'd0, 4'd0,  4'b0000, 2'd1, 4'b0000, 4'd0, 4'd0, 1'b0, 4'd0};

    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      apply(vecs[i], i);
    end

    // Every port must read fully clear after the mid-traffic reset.
    for (int p = 0; p < PC; p++) begin
      apply(idle(PW'(p)), 100 + p);
    end

    // Fill port 3 and drain it with back-to-back pops.
    v = idle(2'd3);
    v.iv = 1'b1; v.ip = 2'd3; v.is = 4'd8;
    v.e_valid = 4'b1000; v.e_slot = 4'd1; v.e_count = 4'd8;
    apply(v, 200);
    for (int k = 1; k <= SC; k++) begin
      v = idle(2'd3);
      v.pop     = 4'b1000;
      v.e_valid = (k < SC) ? 4'b1000 : 4'b0000;
      v.e_slot  = (k < SC) ? SW'(k + 1) : 4'd0;
      v.e_count = SW'(SC - k);
      apply(v, 200 + k);
    end

    // Init on port 3 overrides a same-cycle return and pop there.
    v = idle(2'd3);
    v.iv = 1'b1; v.ip = 2'd3; v.is = 4'd2;
    v.rv = 1'b1; v.rp = 2'd3; v.rs = 4'd7; v.pop = 4'b1000;
    v.e_valid = 4'b1000; v.e_slot = 4'd1; v.e_count = 4'd2;
    apply(v, 300);

    // Duplicate return while port 3 drains: error latched, pop still applies.
    v = idle(2'd3);
    v.rv = 1'b1; v.rp = 2'd3; v.rs = 4'd2; v.pop = 4'b1000;
    v.e_valid = 4'b1000; v.e_slot = 4'd2; v.e_count = 4'd1; v.e_err = 1'b1; v.e_err_slot = 4'd2;
    apply(v, 301);

    if (sb_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
